// File: rtl/decoder_scan_n_pkg.sv
// ---------------------------------------------------------------------------
// decoder_scan_n_pkg
//   Shared definitions for the scanning one-hot decoder: the mode input
//   encoding and the two-state FSM encoding used by the top level.
// ---------------------------------------------------------------------------
package decoder_scan_n_pkg;

    // Values of the 'mode' input
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // FSM state: direct addressing or auto-scan
    typedef enum logic {
        S_DIRECT = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_scan_n_nx2n.sv
// ---------------------------------------------------------------------------
// decoder_nx2n
//   Purely combinational N-to-2^N one-hot decoder with an enable gate.
//   Ports:
//     en   in  1     0 forces every output bit low
//     sel  in  N     index of the bit to drive high
//     y    out 2**N  one-hot result (all zeros when en=0)
// ---------------------------------------------------------------------------
module decoder_nx2n #(
    parameter int N = 2
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y
);

    // Clear everything first, then raise only the selected bit when enabled
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan_n.sv
// ---------------------------------------------------------------------------
// decoder_scan_n
//   Registered one-hot decoder with an auto-scan mode. In direct mode the
//   index is loaded from 'sel'; in scan mode it advances every DWELL cycles
//   and wraps through all OUTS outputs, pulsing 'wrap' on the OUTS-1 -> 0 step.
//   Ports:
//     clk    in  1     rising-edge clock
//     rst_n  in  1     synchronous active-low reset
//     en     in  1     global enable; 0 blanks outputs and freezes counters
//     mode   in  1     0 = direct, 1 = scan
//     sel    in  N     index to load
//     load   in  1     load strobe (idx <= sel) in either mode
//     out    out OUTS  registered one-hot of idx, inverted when ACTIVE_LOW=1
//     idx    out N     current index
//     wrap   out 1     one-cycle pulse on scan wrap-around
// ---------------------------------------------------------------------------
module decoder_scan_n
    import decoder_scan_n_pkg::*;
#(
    parameter  int N          = 2,
    parameter  int DWELL      = 4,
    parameter  int ACTIVE_LOW = 0,
    localparam int OUTS       = 2**N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    input  logic            load,
    output logic [OUTS-1:0] out,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};
    localparam logic [OUTS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUTS{1'b1}} : {OUTS{1'b0}};

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   dwell_cnt;
    logic [CW-1:0]   dwell_next;
    logic [N-1:0]    idx_next;
    logic            wrap_next;
    logic [OUTS-1:0] dec;

    // Next-state logic. With en low everything holds and wrap drops.
    // A load wins over the dwell step. Counting only happens while the
    // registered state and the mode input both say scan, so entering or
    // leaving scan always passes through one cycle with dwell_cnt cleared.
    always_comb begin
        state_next = state;
        dwell_next = dwell_cnt;
        idx_next   = idx;
        wrap_next  = 1'b0;
        if (en) begin
            state_next = (mode == MODE_SCAN) ? S_SCAN : S_DIRECT;
            if (load) begin
                idx_next   = sel;
                dwell_next = '0;
            end else if ((state == S_SCAN) && (mode == MODE_SCAN)) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_next = '0;
                    idx_next   = idx + 1'b1;
                    wrap_next  = (idx == IDX_LAST);
                end else begin
                    dwell_next = dwell_cnt + 1'b1;
                end
            end else begin
                dwell_next = '0;
            end
        end
    end

    // The decoder looks at the next index so that out, idx and wrap all
    // change on the same edge; en gates it so a disabled cycle is blank.
    decoder_nx2n #(.N(N)) u_dec (
        .en  (en),
        .sel (idx_next),
        .y   (dec)
    );

    // State, counters and output register. XOR with the inactive pattern
    // applies the output polarity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_DIRECT;
            dwell_cnt <= '0;
            idx       <= '0;
            wrap      <= 1'b0;
            out       <= INACTIVE;
        end else begin
            state     <= state_next;
            dwell_cnt <= dwell_next;
            idx       <= idx_next;
            wrap      <= wrap_next;
            out       <= dec ^ INACTIVE;
        end
    end

endmodule
